pzbcm_width_downsizer: RTL and testbench

Valid/ready width down-converter: accepts one wide beat of `RATIO` lanes and emits it as up to `RATIO` narrow beats, lane 0 first. It sits directly upstream of a full-bandwidth slicer unit and feeds that unit's narrow input stream. It sustains one narrow beat per cycle with no bubble between consecutive wide beats.

---
 rtl/pzbcm_width_downsizer_pkg.sv | 19 +
 rtl/pzbcm_width_downsizer_lane_select.sv | 26 ++
 rtl/pzbcm_width_downsizer.sv | 121 ++++++++++++
 tb/tb_pzbcm_width_downsizer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pzbcm_width_downsizer_pkg.sv
// pzbcm_width_downsizer_pkg: shared types and helpers for the width downsizer.
package pzbcm_width_downsizer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Width of the beat-count and index fields; never narrower than one bit.
   function automatic int calc_count_width(input int ratio);
      return (ratio <= 2) ? 1 : $clog2(ratio);
   endfunction

   // Counts above the last real lane (non power-of-two ratios) select the last lane.
   function automatic int clamp_count(input int count, input int ratio);
      return (count > ratio - 1) ? ratio - 1 : count;
   endfunction

endpackage

// File: rtl/pzbcm_width_downsizer_lane_select.sv
// pzbcm_width_downsizer_lane_select: combinational mux picking one narrow lane
// out of the wide holding register.
module pzbcm_width_downsizer_lane_select
   import pzbcm_width_downsizer_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int RATIO       = 4,
   parameter int COUNT_WIDTH = calc_count_width(RATIO)
) (
   input  logic [RATIO*WIDTH-1:0] i_data,
   input  logic [COUNT_WIDTH-1:0] i_index,
   output logic [WIDTH-1:0]       o_data
);

   // Compare-based mux so an index past the last lane yields zero, never X.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
      o_data = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (i_index == COUNT_WIDTH'(k)) begin
            o_data = i_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/pzbcm_width_downsizer.sv
// pzbcm_width_downsizer: valid/ready wide-to-narrow converter, lane 0 first,
// one narrow beat per cycle with no bubble between wide beats.
// Optional feature macro PZBCM_WIDTH_DOWNSIZER_PARTIAL_EN: when defined, i_count
// (clamped) selects how many lanes of each wide beat are emitted.
module pzbcm_width_downsizer
   import pzbcm_width_downsizer_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int RATIO       = 4,
   parameter int COUNT_WIDTH = calc_count_width(RATIO)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [RATIO*WIDTH-1:0] i_data,
   input  logic [COUNT_WIDTH-1:0] i_count,
   input  logic                   i_last,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [WIDTH-1:0]       o_data,
   output logic [COUNT_WIDTH-1:0] o_index,
   output logic                   o_last
);

   state_e                 state_d, state_q;
   logic [RATIO*WIDTH-1:0] data_d, data_q;
   logic                   last_d, last_q;
   logic [COUNT_WIDTH-1:0] index_d, index_q;
   logic [COUNT_WIDTH-1:0] final_idx;
   logic                   busy;
   logic                   is_final;
   logic                   accept;

   assign busy     = (state_q == BUSY);
   assign is_final = (index_q == final_idx);
   // Ready depends combinationally on i_ready so the next wide beat can load
   // in the same cycle the final lane leaves.
   assign o_ready  = !busy || (i_ready && is_final);
   assign accept   = i_valid && o_ready;

`ifdef PZBCM_WIDTH_DOWNSIZER_PARTIAL_EN
   logic [COUNT_WIDTH-1:0] final_d, final_q;

   assign final_idx = final_q;

   // Capture the clamped final lane index with each accepted wide beat.
   always_comb begin
      final_d = final_q;
      if (accept) begin
         final_d = COUNT_WIDTH'(clamp_count(int'(i_count), RATIO));
      end
   end

   // Final-index register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         final_q <= '0;
      end else begin
         final_q <= final_d;
      end
   end
`else
   logic unused_count;

   assign final_idx    = COUNT_WIDTH'(RATIO - 1);
   assign unused_count = ^i_count;
`endif

   // Next state: load on wide accept, step the index on narrow handshakes.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      last_d  = last_q;
      index_d = index_q;
      if (accept) begin
         state_d = BUSY;
         data_d  = i_data;
         last_d  = i_last;
         index_d = '0;
      end else if (busy && i_ready) begin
         if (is_final) begin
            state_d = IDLE;
         end else begin
            index_d = index_q + COUNT_WIDTH'(1);
         end
      end
   end

   // State, holding and index registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= IDLE;
         // NOTE: the holding data is reset too, so o_data reads 0 rather than stale data after reset.
         data_q  <= '0;
         last_q  <= 1'b0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         last_q  <= last_d;
         index_q <= index_d;
      end
   end

   assign o_valid = busy;
   assign o_index = index_q;
   assign o_last  = busy && last_q && is_final;

   pzbcm_width_downsizer_lane_select #(
      .WIDTH       (WIDTH),
      .RATIO       (RATIO),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_lane_select (
      .i_data  (data_q),
      .i_index (index_q),
      .o_data  (o_data)
   );

endmodule

// File: tb/tb_pzbcm_width_downsizer.sv
// tb_pzbcm_width_downsizer: directed and randomized checks of the width
// downsizer against a queue-of-narrow-beats reference model.
module tb_pzbcm_width_downsizer;

   localparam int WIDTH = 8;
   localparam int RATIO = 4;

   typedef struct {
      logic [7:0] data;
      int         idx;
      logic       last;
   } beat_t;

   logic        clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_data;
   logic [1:0]  i_count;
   logic        i_last;
   logic        o_valid;
   logic        i_ready;
   logic [7:0]  o_data;
   logic [1:0]  o_index;
   logic        o_last;

   beat_t pending[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   pzbcm_width_downsizer #(
      .WIDTH (WIDTH),
      .RATIO (RATIO)
   ) dut (
      .i_clk   (clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .i_count (i_count),
      .i_last  (i_last),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_index (o_index),
      .o_last  (o_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Number of narrow beats a wide beat produces.
   function automatic int beats_for(input logic [1:0] count);
`ifdef PZBCM_WIDTH_DOWNSIZER_PARTIAL_EN
      return ((int'(count) > RATIO - 1) ? RATIO - 1 : int'(count)) + 1;
`else
      return RATIO;
`endif
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
   // Called at posedge+1.
   task automatic step(input logic v, input logic [31:0] d, input logic [1:0] c,
                       input logic l, input logic r);
      logic  exp_ready;
      int    n;
      beat_t b;
      i_valid = v;
      i_data  = d;
      i_count = c;
      i_last  = l;
      i_ready = r;
      #3;
      // The DUT can take a wide beat when nothing is pending, or when only the
      // final lane remains and it is being consumed this cycle.
      exp_ready = (pending.size() == 0) || (pending.size() == 1 && r);
      check("o_valid", 32'(o_valid), 32'(pending.size() != 0));
      check("o_ready", 32'(o_ready), 32'(exp_ready));
      if (pending.size() != 0) begin
         check("o_data",  32'(o_data),  32'(pending[0].data));
         check("o_index", 32'(o_index), 32'(pending[0].idx));
         check("o_last",  32'(o_last),  32'(pending[0].last));
      end else begin
         check("o_last_idle", 32'(o_last), 32'd0);
      end
      @(posedge clk);
      if (pending.size() != 0 && r) void'(pending.pop_front());
      if (v && exp_ready) begin
         n = beats_for(c);
         for (int k = 0; k < n; k++) begin
            b.data = d[k*8 +: 8];
            b.idx  = k;
            b.last = l && (k == n - 1);
            pending.push_back(b);
         end
      end
      #1;
   endtask

   // One cycle with reset asserted; pending model beats are discarded.
   task automatic reset_cycle();
      i_rst   = 1'b1;
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
      i_data  = $urandom;
      @(posedge clk);
      pending.delete();
      #1;
      i_rst   = 1'b0;
      i_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      i_valid = 1'b0;
      #3;
      check({tag, "_o_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_o_ready"}, 32'(o_ready), 32'd1);
      check({tag, "_o_index"}, 32'(o_index), 32'd0);
      check({tag, "_o_data"},  32'(o_data),  32'd0);
      check({tag, "_o_last"},  32'(o_last),  32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      i_count = '0;
      i_last  = 1'b0;
      i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      i_rst = 1'b0;
      check_reset_values("reset");

      // Single beat, all lanes, last set.
      step(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b1);
      repeat (4) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

      // Back-to-back wide beats with valid and ready held high.
      step(1'b1, 32'h44332211, 2'd3, 1'b0, 1'b1);
      repeat (3) step(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1);
      step(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1);
      repeat (4) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

      // Ready toggling 1,0,0,1 while a new wide beat waits.
      step(1'b1, 32'hddccbbaa, 2'd3, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 32'h0f0e0d0c, 2'd3, 1'b0, (i % 4 == 0) || (i % 4 == 3));
      end
      repeat (8) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

      // Partial count request (all lanes in the default build).
      step(1'b1, 32'h44332211, 2'd1, 1'b1, 1'b1);
      repeat (5) step(1'b1, 32'h88776655, 2'd3, 1'b0, 1'b1);
      repeat (6) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

      // Reset while lane 2 is stalled.
      step(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b1);
      step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      reset_cycle();
      check_reset_values("midreset");
      step(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1);
      repeat (5) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_cycle();
         end else begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
